// File: rtl/sqrt_operand_prep.sv
// Operand front-end for the FP sqrt / inverse-sqrt core: classify, resolve specials, build 1.8 mantissa.
// Define SQRT_PREP_DENORM_EN to normalise denormals instead of flushing them to signed zero.
module sqrt_operand_prep #(
    parameter int          EXP_W = 10,
    parameter logic [15:0] QNAN  = 16'h7FC0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic [15:0]             op_i,
    input  logic                    inv_i,
    output logic                    core_do_sqrt_o,
    output logic                    core_do_invsqrt_o,
    output logic [8:0]              core_s_o,
    input  logic                    core_valid_i,
    output logic                    valid_o,
    output logic                    special_o,
    output logic [15:0]             special_res_o,
    output logic                    sign_o,
    output logic signed [EXP_W-1:0] exp_o,
    output logic                    flag_invalid_o,
    output logic                    flag_dz_o
);

    typedef enum logic [2:0] {IDLE, SPEC, NORM, ISSUE, WAIT} state_t;

    state_t      state;
    logic        inv_q;
    logic [15:0] res_q;
    logic        invalid_q;
    logic        dz_q;

    // Odd exponents pre-halve the mantissa so the core always sees an even power of two.
    function automatic logic [8:0] mant_fix(
        input logic signed [EXP_W-1:0] e,
        input logic [6:0]              m
    );
        return e[0] ? {2'b01, m} : {1'b1, m, 1'b0};
    endfunction

    function automatic logic signed [EXP_W-1:0] res_exp(
        input logic signed [EXP_W-1:0] e,
        input logic                    inv
    );
        logic signed [EXP_W-1:0] re;
        re = $signed(e + EXP_W'(e[0])) >>> 1;
        return inv ? -re : re;
    endfunction

    logic                    in_s;
    logic [7:0]              in_e;
    logic [6:0]              in_m;
    logic signed [EXP_W-1:0] in_unb;
    logic                    is_nan;
    logic                    is_zero;
    logic                    is_inf;

    assign in_s   = op_i[15];
    assign in_e   = op_i[14:7];
    assign in_m   = op_i[6:0];
    assign in_unb = EXP_W'(in_e) - EXP_W'(127);
    assign is_nan = (in_e == 8'hFF) && (in_m != 7'd0);
    assign is_inf = (in_e == 8'hFF) && (in_m == 7'd0);

`ifdef SQRT_PREP_DENORM_EN
    logic                    is_denorm;
    logic [6:0]              den_m_q;
    logic [2:0]              lz;
    logic [6:0]              ms;
    logic signed [EXP_W-1:0] den_e;
    logic [6:0]              den_m;

    assign is_zero   = (in_e == 8'd0) && (in_m == 7'd0);
    assign is_denorm = (in_e == 8'd0) && (in_m != 7'd0);

    always_comb begin
        lz = '0;
        for (int i = 0; i < 7; i++) begin
            if (den_m_q[i]) lz = 3'(6 - i);
        end
        ms    = den_m_q << lz;
        den_m = {ms[5:0], 1'b0};
        den_e = EXP_W'(-127) - EXP_W'(lz);
    end
`else
    assign is_zero = (in_e == 8'd0);
`endif

    logic        is_special;
    logic [15:0] spec_res;
    logic        spec_invalid;
    logic        spec_dz;

    always_comb begin
        is_special   = 1'b1;
        spec_res     = '0;
        spec_invalid = 1'b0;
        spec_dz      = 1'b0;
        if (is_nan) begin
            spec_res     = QNAN;
            spec_invalid = 1'b1;
        end else if (in_s && !is_zero) begin
            spec_res     = QNAN;
            spec_invalid = 1'b1;
        end else if (is_zero) begin
            spec_res = inv_i ? {in_s, 8'hFF, 7'h0} : {in_s, 15'h0};
            spec_dz  = inv_i;
        end else if (is_inf) begin
            spec_res = inv_i ? 16'h0000 : 16'h7F80;
        end else begin
            is_special = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            inv_q     <= 1'b0;
            res_q     <= '0;
            invalid_q <= 1'b0;
            dz_q      <= 1'b0;
            core_s_o  <= '0;
            exp_o     <= '0;
`ifdef SQRT_PREP_DENORM_EN
            den_m_q   <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (valid_i) begin
                        inv_q <= inv_i;
                        if (is_special) begin
                            res_q     <= spec_res;
                            invalid_q <= spec_invalid;
                            dz_q      <= spec_dz;
                            state     <= SPEC;
`ifdef SQRT_PREP_DENORM_EN
                        end else if (is_denorm) begin
                            den_m_q <= in_m;
                            state   <= NORM;
`endif
                        end else begin
                            core_s_o <= mant_fix(in_unb, in_m);
                            exp_o    <= res_exp(in_unb, inv_i);
                            state    <= ISSUE;
                        end
                    end
                end
                SPEC: state <= IDLE;
                NORM: begin
`ifdef SQRT_PREP_DENORM_EN
                    core_s_o <= mant_fix(den_e, den_m);
                    exp_o    <= res_exp(den_e, inv_q);
`endif
                    state <= ISSUE;
                end
                ISSUE: state <= WAIT;
                WAIT: if (core_valid_i) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    logic spec_st;
    assign spec_st           = (state == SPEC);
    assign ready_o           = (state == IDLE);
    assign core_do_sqrt_o    = (state == ISSUE) && !inv_q;
    assign core_do_invsqrt_o = (state == ISSUE) && inv_q;
    assign valid_o           = spec_st || ((state == WAIT) && core_valid_i);
    assign special_o         = spec_st;
    assign special_res_o     = spec_st ? res_q : 16'h0000;
    assign sign_o            = spec_st && res_q[15];
    assign flag_invalid_o    = spec_st && invalid_q;
    assign flag_dz_o         = spec_st && dz_q;

endmodule

// File: tb/tb_sqrt_operand_prep.sv
// Randomised bench for sqrt_operand_prep with a value-level reference model and a mock core.
module tb_sqrt_operand_prep;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              valid_i = 1'b0;
    logic              ready_o;
    logic [15:0]       op_i = '0;
    logic              inv_i = 1'b0;
    logic              core_do_sqrt_o;
    logic              core_do_invsqrt_o;
    logic [8:0]        core_s_o;
    logic              core_valid_i = 1'b0;
    logic              valid_o;
    logic              special_o;
    logic [15:0]       special_res_o;
    logic              sign_o;
    logic signed [9:0] exp_o;
    logic              flag_invalid_o;
    logic              flag_dz_o;

    sqrt_operand_prep dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
        .op_i(op_i), .inv_i(inv_i),
        .core_do_sqrt_o(core_do_sqrt_o), .core_do_invsqrt_o(core_do_invsqrt_o),
        .core_s_o(core_s_o), .core_valid_i(core_valid_i),
        .valid_o(valid_o), .special_o(special_o), .special_res_o(special_res_o),
        .sign_o(sign_o), .exp_o(exp_o),
        .flag_invalid_o(flag_invalid_o), .flag_dz_o(flag_dz_o)
    );

    always #5 clk = ~clk;

`ifdef SQRT_PREP_DENORM_EN
    localparam bit DEN = 1'b1;
`else
    localparam bit DEN = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Reference: value = sig/128 * 2^e with sig in [128,255]; sqrt halves the exponent.
    task automatic model(
        input  logic [15:0] op,
        input  bit          inv,
        output bit          spec,
        output logic [15:0] res,
        output bit          finv,
        output bit          dz,
        output bit          denorm,
        output int          cs,
        output int          ex
    );
        int E, M, sig, e, re;
        bit s, zero;
        E = int'(op[14:7]);
        M = int'(op[6:0]);
        s = op[15];
        zero = (E == 0) && (M == 0 || !DEN);
        spec = 1; res = 0; finv = 0; dz = 0; denorm = 0; cs = 0; ex = 0;
        if (E == 255 && M != 0) begin
            res = 16'h7FC0; finv = 1;
        end else if (s && !zero) begin
            res = 16'h7FC0; finv = 1;
        end else if (zero) begin
            if (inv) res = s ? 16'hFF80 : 16'h7F80;
            else     res = s ? 16'h8000 : 16'h0000;
            dz = inv;
        end else if (E == 255) begin
            res = inv ? 16'h0000 : 16'h7F80;
        end else begin
            spec = 0;
            denorm = (E == 0);
            sig = denorm ? M : 128 + M;
            e = denorm ? -126 : E - 127;
            while (sig < 128) begin
                sig = sig * 2;
                e = e - 1;
            end
            if (e % 2 == 0) begin
                cs = sig * 2; re = e / 2;
            end else begin
                cs = sig; re = (e + 1) / 2;
            end
            ex = inv ? -re : re;
        end
    endtask

    task automatic run_op(input logic [15:0] op, input bit inv);
        bit spec, finv, dz, denorm;
        logic [15:0] res;
        int cs, ex, d;
        model(op, inv, spec, res, finv, dz, denorm, cs, ex);
        @(negedge clk);
        check("ready_idle", ready_o, 1);
        valid_i = 1; op_i = op; inv_i = inv;
        @(negedge clk);
        valid_i = 0; op_i = 16'($urandom);
        if (spec) begin
            check("spec_valid", {valid_o, special_o}, 2'b11);
            check("spec_res", special_res_o, res);
            check("spec_flags", {flag_invalid_o, flag_dz_o}, {finv, dz});
            check("spec_sign", sign_o, res[15]);
            check("spec_nopulse", {core_do_sqrt_o, core_do_invsqrt_o, ready_o}, 0);
        end else begin
            if (denorm) begin
                check("norm_quiet", {valid_o, core_do_sqrt_o, core_do_invsqrt_o, ready_o}, 0);
                @(negedge clk);
            end
            check("issue_pulse", {core_do_sqrt_o, core_do_invsqrt_o}, {!inv, inv});
            check("issue_s", core_s_o, cs);
            check("issue_exp", 32'(exp_o), ex);
            check("issue_busy", {valid_o, ready_o}, 0);
            d = $urandom_range(0, 3);
            @(negedge clk);
            repeat (d) begin
                valid_i = 1'($urandom); op_i = 16'($urandom); inv_i = 1'($urandom);
                #1;
                check("wait_quiet", {valid_o, core_do_sqrt_o, core_do_invsqrt_o, ready_o}, 0);
                check("wait_s", core_s_o, cs);
                @(negedge clk);
            end
            valid_i = 0;
            core_valid_i = 1;
            #1;
            check("done_valid", {valid_o, special_o, ready_o}, 3'b100);
            check("done_exp", 32'(exp_o), ex);
            check("done_s", core_s_o, cs);
            check("done_side", {sign_o, flag_invalid_o, flag_dz_o}, 0);
            @(negedge clk);
            core_valid_i = 0;
            check("ready_back", ready_o, 1);
        end
    endtask

    initial begin
        logic [15:0] op;
        repeat (2) @(negedge clk);
        rst = 0;
        check("rst_ready", ready_o, 1);
        check("rst_outs", {valid_o, special_o, core_do_sqrt_o, core_do_invsqrt_o,
                           sign_o, flag_invalid_o, flag_dz_o}, 0);
        check("rst_s", core_s_o, 0);
        check("rst_exp", 32'(exp_o), 0);
        check("rst_res", special_res_o, 0);

        core_valid_i = 1;
        #1;
        check("idle_core_ignored", valid_o, 0);
        core_valid_i = 0;

        run_op(16'h4080, 0);
        run_op(16'h4000, 0);
        run_op(16'h4080, 1);
        run_op(16'hBF80, 0);
        run_op(16'h0000, 1);
        run_op(16'h8000, 0);
        run_op(16'h8000, 1);
        run_op(16'h7F80, 1);
        run_op(16'h7F80, 0);
        run_op(16'h7FC1, 0);
        run_op(16'hFF80, 1);
        run_op(16'h0040, 0);
        run_op(16'h0001, 1);
        run_op(16'h8040, 0);
        run_op(16'h3F80, 1);
        run_op(16'h7F7F, 0);

        // Reset while waiting on the core must drop the operand.
        @(negedge clk);
        valid_i = 1; op_i = 16'h4080; inv_i = 0;
        @(negedge clk);
        valid_i = 0;
        check("rw_issue", core_do_sqrt_o, 1);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("rw_ready", ready_o, 1);
        check("rw_s", core_s_o, 0);
        core_valid_i = 1;
        #1;
        check("rw_novalid", valid_o, 0);
        core_valid_i = 0;

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) < 6)
                op = {1'b0, 8'($urandom_range(1, 254)), 7'($urandom)};
            else if ($urandom_range(0, 1) == 1)
                op = {1'($urandom), 8'h00, 7'($urandom)};
            else
                op = 16'($urandom);
            run_op(op, 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
